// File: rtl/pwm_pkg.sv
// Shared types and constants for the breathing-LED PWM sequencer.
package pwm_pkg;

   localparam int unsigned DUTY_W     = 4;
   localparam int unsigned DUTY_STEPS = 16;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] RAMP_UP   = 3'd1;
   localparam logic [2:0] HOLD_HIGH = 3'd2;
   localparam logic [2:0] RAMP_DOWN = 3'd3;
   localparam logic [2:0] HOLD_LOW  = 3'd4;

   typedef enum logic [2:0] {
      StIdle     = IDLE,
      StRampUp   = RAMP_UP,
      StHoldHigh = HOLD_HIGH,
      StRampDown = RAMP_DOWN,
      StHoldLow  = HOLD_LOW
   } state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM core: free-running period counter, period-aligned duty shadow, registered LED compare.
module pwm_core
   import pwm_pkg::*;
#(
   parameter int unsigned PWM_PERIOD = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DUTY_W-1:0] duty,
   output logic              led,
   output logic              period_end
);

   localparam int unsigned PCNT_W = $clog2(PWM_PERIOD);
   localparam int unsigned LIM_W  = PCNT_W + 1;
   localparam int unsigned SLICE  = PWM_PERIOD / DUTY_STEPS;

   logic [PCNT_W-1:0] pcnt_q;
   logic [DUTY_W-1:0] duty_act_q;
   logic [LIM_W-1:0]  limit;
   logic              led_q;

   assign period_end = (pcnt_q == PCNT_W'(PWM_PERIOD - 1));
   // One extra bit so duty*slice can never wrap.
   assign limit      = LIM_W'(duty_act_q) * LIM_W'(SLICE);
   assign led        = led_q;

   // Period counter, duty shadow (only updated at a period boundary) and LED compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q     <= '0;
         duty_act_q <= '0;
         led_q      <= 1'b0;
      end else begin
         if (clr || period_end) begin
            pcnt_q <= '0;
         end else begin
            pcnt_q <= pcnt_q + 1'b1;
         end
         if (period_end) begin
            duty_act_q <= duty;
         end
         led_q <= ({1'b0, pcnt_q} < limit);
      end
   end

endmodule

// File: rtl/pwm_breath_sequencer.sv
// Breathing profile sequencer: ramp up, hold, ramp down, hold; optionally looping.
module pwm_breath_sequencer
   import pwm_pkg::*;
#(
   parameter int unsigned PWM_PERIOD   = 100000,
   parameter int unsigned STEP_PERIODS = 16,
   parameter int unsigned HOLD_PERIODS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [DUTY_W-1:0] max_duty,
   output logic              led,
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(max2(STEP_PERIODS, HOLD_PERIODS) + 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(DUTY_STEPS - 1);

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] pk_q, pk_d;
   logic [CNT_W-1:0]  step_q, step_d;
   logic [CNT_W-1:0]  hold_q, hold_d;
   logic              loop_q, loop_d;
   logic              done_q, done_d;
   logic              clr;
   logic              period_end;
   logic              step_last;
   logic              hold_last;

   pwm_core #(
      .PWM_PERIOD(PWM_PERIOD)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .duty      (duty_q),
      .led       (led),
      .period_end(period_end)
   );

   assign step_last = (step_q == CNT_W'(STEP_PERIODS - 1));
   assign hold_last = (hold_q == CNT_W'(HOLD_PERIODS - 1));

   // Next-state: profile FSM plus step/hold counters, all advanced on period boundaries.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      pk_d    = pk_q;
      step_d  = step_q;
      hold_d  = hold_q;
      loop_d  = loop_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // stop in the same cycle vetoes the start.
            if (start && !stop) begin
               pk_d    = max_duty;
               clr     = 1'b1;
               duty_d  = '0;
               step_d  = '0;
               hold_d  = '0;
               loop_d  = 1'b1;
               state_d = (max_duty == '0) ? StHoldLow : StRampUp;
            end
         end
         StRampUp: begin
            if (stop) begin
               state_d = StRampDown;
               step_d  = '0;
               loop_d  = 1'b0;
            end else if (period_end) begin
               if (step_last) begin
                  step_d = '0;
                  if (duty_q != DUTY_MAX) duty_d = duty_q + 1'b1;
                  if (duty_d >= pk_q) begin
                     state_d = StHoldHigh;
                     hold_d  = '0;
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         StHoldHigh: begin
            if (stop) begin
               state_d = StRampDown;
               step_d  = '0;
               loop_d  = 1'b0;
            end else if (period_end) begin
               if (hold_last) begin
                  state_d = StRampDown;
                  step_d  = '0;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         StRampDown: begin
            if (stop) loop_d = 1'b0;
            if (period_end) begin
               if (step_last) begin
                  step_d = '0;
                  if (duty_q != '0) duty_d = duty_q - 1'b1;
                  if (duty_d == '0) begin
                     state_d = StHoldLow;
                     hold_d  = '0;
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         StHoldLow: begin
            if (stop) loop_d = 1'b0;
            if (period_end) begin
               if (hold_last) begin
                  hold_d = '0;
                  if (loop_en && loop_d) begin
                     step_d  = '0;
                     // A zero peak just repeats the low hold.
                     state_d = (pk_q == '0) ? StHoldLow : StRampUp;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         duty_q  <= '0;
         pk_q    <= '0;
         step_q  <= '0;
         hold_q  <= '0;
         loop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         pk_q    <= pk_d;
         step_q  <= step_d;
         hold_q  <= hold_d;
         loop_q  <= loop_d;
         done_q  <= done_d;
      end
   end

   assign duty = duty_q;
   assign busy = (state_q != StIdle);
   assign done = done_q;

endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// Scoreboard bench: expected duty/done events are queued from a period-level model,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pwm_breath_sequencer;

   localparam int P  = 32;
   localparam int S  = 2;
   localparam int H  = 3;
   localparam int SL = S * P;   // cycles per ramp step
   localparam int HL = H * P;   // cycles per hold

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop_en = 1'b0;
   logic [3:0] max_duty = 4'd0;
   logic       led;
   logic [3:0] duty;
   logic       busy;
   logic       done;

   pwm_breath_sequencer #(
      .PWM_PERIOD  (P),
      .STEP_PERIODS(S),
      .HOLD_PERIODS(H)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .loop_en (loop_en),
      .max_duty(max_duty),
      .led     (led),
      .duty    (duty),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int t;
      bit is_done;
      int val;
   } ev_t;

   ev_t  exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   logic [3:0] prev_duty;
   int   led_cnt = 0;
   int   win_lo = -1000;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_ev(input int t, input bit is_done, input int val);
      ev_t e;
      e.t = t;
      e.is_done = is_done;
      e.val = val;
      exp_q.push_back(e);
   endtask

   // Full profile from start cycle s with peak pk; returns the cycle HOLD_LOW expires.
   task automatic model_run(input int s, input int pk, input bit with_done, output int t_end);
      int t_hh;
      int t_hl;
      for (int k = 1; k <= pk; k++) push_ev(s + k * SL, 1'b0, k);
      t_hh = s + pk * SL;
      for (int j = 1; j <= pk; j++) push_ev(t_hh + HL + j * SL, 1'b0, pk - j);
      t_hl = t_hh + HL + pk * SL;
      if (pk == 0) t_hl = s;
      t_end = t_hl + HL;
      if (with_done) push_ev(t_end, 1'b1, 0);
   endtask

   // Graceful stop at cycle x with duty d (d >= 1), period grid anchored at s.
   task automatic model_stop(input int s, input int x, input int d);
      int p1;
      int t_hl;
      p1 = s + P * ((x - s) / P + 1);
      for (int j = 1; j <= d; j++) push_ev(p1 + (S - 1) * P + (j - 1) * SL, 1'b0, d - j);
      t_hl = p1 + (S - 1) * P + (d - 1) * SL;
      push_ev(t_hl + HL, 1'b1, 0);
   endtask

   task automatic handle_ev(input bit is_done, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected event: actual done=%0d duty=%0d required none (cycle %0d)",
                  is_done, val, cyc);
      end else begin
         e = exp_q.pop_front();
         check("event kind (1=done)", int'(is_done), int'(e.is_done));
         check("event cycle", cyc, e.t);
         check("event duty", val, e.val);
      end
   endtask

   // Monitor: samples on the falling edge, turns duty changes and done pulses into events.
   always @(negedge clk) begin
      if (cyc >= win_lo && cyc < win_lo + 32 && led === 1'b1) led_cnt++;
      if (!mon_en || rst) begin
         prev_duty = duty;
      end else begin
         if (duty !== prev_duty) handle_ev(1'b0, int'(duty));
         if (done === 1'b1) begin
            handle_ev(1'b1, 0);
            check("busy low with done", int'(busy), 0);
         end
         prev_duty = duty;
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [3:0] md, output int s);
      max_duty = md;
      start = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop_at(input int x);
      wait_cyc(x - 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic spurious_start_at(input int c);
      wait_cyc(c);
      start = 1'b1;
      max_duty = 4'($urandom_range(0, 15));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int lim);
      for (int i = 0; i < lim && exp_q.size() != 0; i++) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   task automatic idle_check(input string name, input int n);
      int b = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy !== 1'b0) b++;
      end
      check(name, b, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int t_end;
      int x;
      int pk;

      // Reset from power-up.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset led", int'(led), 0);
      check("reset duty", int'(duty), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Idle (duty 0): LED never high.
      led_cnt = 0;
      win_lo = cyc + 2;
      wait_cyc(win_lo + 33);
      check("led count at duty 0", led_cnt, 0);

      // Reset held 3 cycles in the middle of HOLD_HIGH.
      pulse_start(4'd3, s);
      for (int k = 1; k <= 3; k++) push_ev(s + k * SL, 1'b0, k);
      wait_cyc(s + 3 * SL + 40);
      check("events before reset", exp_q.size(), 0);
      rst = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid-run reset led", int'(led), 0);
         check("mid-run reset duty", int'(duty), 0);
         check("mid-run reset busy", int'(busy), 0);
         check("mid-run reset done", int'(done), 0);
      end
      rst = 1'b0;
      idle_check("idle after reset", 20);

      // Single profile, peak 4, with a spurious start mid-run.
      loop_en = 1'b0;
      pulse_start(4'd4, s);
      model_run(s, 4, 1'b1, t_end);
      wait_cyc(s + 20);
      check("busy during profile", int'(busy), 1);
      spurious_start_at(s + $urandom_range(30, 690));
      wait_drain("peak 4 profile drained", 2000);
      idle_check("idle after peak 4", 40);

      // Peak 15: LED high exactly 30 of 32 cycles during HOLD_HIGH.
      pulse_start(4'd15, s);
      model_run(s, 15, 1'b1, t_end);
      led_cnt = 0;
      win_lo = s + 15 * SL + 40;
      wait_drain("peak 15 profile drained", 3000);
      check("led count at duty 15", led_cnt, 30);

      // Stop during RAMP_UP at duty 2 with looping requested: ends at IDLE.
      loop_en = 1'b1;
      pk = $urandom_range(3, 15);
      pulse_start(4'(pk), s);
      push_ev(s + SL, 1'b0, 1);
      push_ev(s + 2 * SL, 1'b0, 2);
      x = s + 2 * SL + $urandom_range(1, SL);
      model_stop(s, x, 2);
      pulse_stop_at(x);
      wait_drain("stop in ramp up drained", 1500);
      idle_check("no restart after stop", 200);

      // Looping peak 2: re-enters RAMP_UP without done; mid-run start and max_duty ignored.
      pulse_start(4'd2, s);
      model_run(s, 2, 1'b0, t_end);
      push_ev(t_end + SL, 1'b0, 1);
      push_ev(t_end + 2 * SL, 1'b0, 2);
      wait_cyc(s + $urandom_range(10, 400));
      start = 1'b1;
      max_duty = 4'd9;
      @(negedge clk);
      start = 1'b0;
      x = t_end + 2 * SL + $urandom_range(1, HL);
      model_stop(s, x, 2);
      pulse_stop_at(x);
      wait_drain("loop profile drained", 2000);
      idle_check("idle after loop stop", 40);

      // start and stop together while idle: nothing starts.
      loop_en = 1'b0;
      max_duty = 4'd5;
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      idle_check("start+stop ignored", 100);

      // Peak 0: straight to HOLD_LOW, then done.
      pulse_start(4'd0, s);
      model_run(s, 0, 1'b1, t_end);
      wait_cyc(s + 50);
      check("busy in zero-peak hold", int'(busy), 1);
      wait_drain("zero peak drained", 500);
      idle_check("idle after zero peak", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
